// File: rtl/uart_tx_buffer_reg.sv
// Avalon-MM register front end with a first-word-fall-through transmit FIFO
// feeding a UART serialiser; overflow flag, threshold and overflow interrupts.
module uart_tx_buffer_reg #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [31:0]      DEPTH_32 = 32'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] hold;
  logic [7:0]        thresh;
  logic              ovf;
  logic              txen;
  logic              ien_thr;
  logic              ien_ovf;

  logic        wr;
  logic        wr_data;
  logic        wr_stat;
  logic        wr_ctrl;
  logic        wr_thr;
  logic        flush;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        ovf_set;
  logic        thr_hit;
  logic [31:0] lvl_ext;
  logic [31:0] thr_ext;
  logic [31:0] thr_in;
  logic        unused_bits;

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr & (address == 2'd0);
  assign wr_stat = wr & (address == 2'd1);
  assign wr_ctrl = wr & (address == 2'd2);
  assign wr_thr  = wr & (address == 2'd3);
  assign flush   = wr_ctrl & writedata[3];

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign push    = wr_data & ~full;
  assign ovf_set = wr_data & full;
  // A flush takes precedence over the serialiser's handshake in the same cycle.
  assign pop     = tx_valid & tx_ready & ~flush;

  assign tx_valid = ~empty & txen;
  assign tx_data  = empty ? '0 : mem[rd_ptr];

  assign lvl_ext = {{(32-LVL_W){1'b0}}, level};
  assign thr_ext = {24'd0, thresh};
  assign thr_in  = {24'd0, writedata[7:0]};
  assign thr_hit = (lvl_ext <= thr_ext);

  assign unused_bits = ^writedata;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold    <= '0;
      ovf     <= 1'b0;
      txen    <= 1'b0;
      ien_thr <= 1'b0;
      ien_ovf <= 1'b0;
      thresh  <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_data) hold <= writedata[DATA_W-1:0];
      // Overflow set has priority over a software clear.
      if (ovf_set)                    ovf <= 1'b1;
      else if (wr_stat && writedata[2]) ovf <= 1'b0;
      if (wr_ctrl) begin
        txen    <= writedata[0];
        ien_thr <= writedata[1];
        ien_ovf <= writedata[2];
      end
      if (wr_thr) thresh <= (thr_in > DEPTH_32) ? 8'(DEPTH) : writedata[7:0];
      irq <= (ien_thr & thr_hit) | (ien_ovf & ovf);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {{(32-DATA_W){1'b0}}, hold};
      2'd1: readdata = {8'd0, lvl_ext[7:0], 12'd0, irq, ovf, full, empty};
      2'd2: readdata = {29'd0, ien_ovf, ien_thr, txen};
      2'd3: readdata = thr_ext;
      default: readdata = '0;
    endcase
  end

endmodule
